// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: register width, register-index width,
// architectural register names and the register-index type.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd2;

endpackage : riscv_pkg

// File: rtl/reg_file.sv
// RV32I integer register file.
// - 31 stored registers (x1-x31). x0 is hard-wired to zero.
// - Two combinational operand read ports with optional same-cycle write forwarding.
// - One clocked write port.
// - One combinational debug read port that never forwards.
module reg_file
    import riscv_pkg::*;
#(
    parameter int                        XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]           SP_RESET = 32'h0000_0FFC,
    parameter int                        BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [4:0]            rd_addr,
    input  logic [XLEN-1:0]       rd_data,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic [4:0]            dbg_addr,
    output logic [XLEN-1:0]       dbg_data
);

    logic [XLEN-1:0] regs_q [1:31];
    logic [XLEN-1:0] regs_d [1:31];

    // A write that really lands at the next edge: enabled, not to x0, not under reset.
    logic wr_live;
    assign wr_live = rst_n && reg_write && (rd_addr != REG_ZERO);

    // Common read path for every port.
    // Order of precedence:
    // 1. x0 always reads zero.
    // 2. Otherwise a live write to the same index is forwarded (only when allowed).
    // 3. Otherwise the stored value is returned.
    function automatic logic [XLEN-1:0] rd_port(input reg_addr_t addr, input logic byp_en);
        logic [XLEN-1:0] val;
        if (addr == REG_ZERO)
            val = '0;
        else if (byp_en && (BYPASS != 0) && wr_live && (addr == rd_addr))
            val = rd_data;
        else
            val = regs_q[addr];
        return val;
    endfunction

    // Next-state of the array: only the addressed register takes new data.
    always_comb begin
        regs_d = regs_q;
        if (wr_live)
            regs_d[rd_addr] = rd_data;
    end

    // Storage update.
    // Reset wins over any concurrent write, and loads the stack pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports. The debug port observes stored state only.
    always_comb begin
        rs1_data = rd_port(rs1_addr, 1'b1);
        rs2_data = rd_port(rs2_addr, 1'b1);
        dbg_data = rd_port(dbg_addr, 1'b0);
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// Two instances share all inputs: one built with forwarding, one without.
// Expected values come from a plain array model updated at each edge.
module tb_reg_file;

    localparam logic [31:0] SP = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst_n, reg_write;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr, dbg_addr;
    logic [31:0] rd_data;
    logic [31:0] b1_rs1, b1_rs2, b1_dbg, b0_rs1, b0_rs2, b0_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model [0:31];

    always #5 clk = ~clk;

    reg_file #(.XLEN(32), .SP_RESET(SP), .BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b1_rs1), .rs2_data(b1_rs2),
        .dbg_addr(dbg_addr), .dbg_data(b1_dbg));

    reg_file #(.XLEN(32), .SP_RESET(SP), .BYPASS(0)) dut_nob (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b0_rs1), .rs2_data(b0_rs2),
        .dbg_addr(dbg_addr), .dbg_data(b0_dbg));

    // Architectural view of a read:
    // - x0 is zero.
    // - A forwarding port sees a pending live write.
    // - Otherwise the port sees the model's stored value.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst_n && reg_write && rd_addr != 5'd0 && rd_addr == a) return rd_data;
        return model[a];
    endfunction

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] ad);
        rst_n = rst; reg_write = we; rd_addr = rd; rd_data = d;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        #2;
    endtask

    // Clock edge, with the model applying the same edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model[2] = SP;
        end else if (reg_write && rd_addr != 5'd0) begin
            model[rd_addr] = rd_data;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        for (int a = 0; a < 32; a++) begin
            logic [31:0] e;
            e = (a == 2) ? SP : 32'h0;
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 5'(a));
            n_checks++;
            if (b1_rs1 !== e) $display("FAIL reset_rs1 a=%0d got %h exp %h", a, b1_rs1, e);
            else n_pass++;
            n_checks++;
            if (b1_dbg !== e) $display("FAIL reset_dbg a=%0d got %h exp %h", a, b1_dbg, e);
            else n_pass++;
            n_checks++;
            if (b0_rs2 !== ((31 - a == 2) ? SP : 32'h0))
                $display("FAIL reset_rs2_nob a=%0d got %h", a, b0_rs2);
            else n_pass++;
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        n_checks++;
        if (b1_rs1 !== 32'h0) $display("FAIL x0_same_cycle got %h exp 0", b1_rs1);
        else n_pass++;
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        n_checks++;
        if (b1_rs1 !== 32'h0 || b0_rs1 !== 32'h0 || b1_dbg !== 32'h0)
            $display("FAIL x0_after_edge got %h/%h/%h exp 0", b1_rs1, b0_rs1, b1_dbg);
        else n_pass++;
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd5, 32'd23, 5'd5, 5'd0, 5'd5);
        n_checks++;
        if (b1_rs1 !== 32'd23) $display("FAIL bypass_x5 got %h exp %h", b1_rs1, 32'd23);
        else n_pass++;
        n_checks++;
        if (b1_dbg !== 32'h0) $display("FAIL dbg_no_bypass got %h exp 0", b1_dbg);
        else n_pass++;
        step();
        drive(1'b1, 1'b1, 5'd6, 32'd42, 5'd5, 5'd6, 5'd6);
        n_checks++;
        if (b1_rs1 !== 32'd23 || b1_rs2 !== 32'd42)
            $display("FAIL bypass_x6 got %h/%h exp 23/42", b1_rs1, b1_rs2);
        else n_pass++;
        n_checks++;
        if (b1_dbg !== 32'h0) $display("FAIL dbg_old_x6 got %h exp 0", b1_dbg);
        else n_pass++;
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd6);
        n_checks++;
        if (b1_dbg !== 32'd42 || b0_rs2 !== 32'd42)
            $display("FAIL x6_stored got %h/%h exp 42", b1_dbg, b0_rs2);
        else n_pass++;
    endtask

    task automatic test_dual_bypass();
        drive(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd7);
        n_checks++;
        if (b1_rs1 !== 32'h1234_5678 || b1_rs2 !== 32'h1234_5678)
            $display("FAIL dual_bypass got %h/%h exp 12345678", b1_rs1, b1_rs2);
        else n_pass++;
        n_checks++;
        if (b0_rs1 !== 32'h0 || b0_rs2 !== 32'h0)
            $display("FAIL dual_nob_old got %h/%h exp 0", b0_rs1, b0_rs2);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_during_write();
        drive(1'b1, 1'b1, 5'd2, 32'd77, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd2, 32'd99, 5'd2, 5'd2, 5'd2);
        n_checks++;
        if (b1_rs1 !== 32'd77 || b1_rs2 !== 32'd77)
            $display("FAIL rst_no_bypass got %h/%h exp %h", b1_rs1, b1_rs2, 32'd77);
        else n_pass++;
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd7, 5'd2);
        n_checks++;
        if (b1_rs1 !== SP || b0_dbg !== SP)
            $display("FAIL rst_x2 got %h/%h exp %h", b1_rs1, b0_dbg, SP);
        else n_pass++;
        n_checks++;
        if (b1_rs2 !== 32'h0) $display("FAIL rst_x7 got %h exp 0", b1_rs2);
        else n_pass++;
    endtask

    task automatic test_no_bypass_build();
        drive(1'b1, 1'b1, 5'd9, 32'd55, 5'd9, 5'd9, 5'd9);
        n_checks++;
        if (b0_rs1 !== 32'h0 || b1_rs1 !== 32'd55)
            $display("FAIL nob_write_cycle got %h/%h exp 0/55", b0_rs1, b1_rs1);
        else n_pass++;
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
        n_checks++;
        if (b0_rs1 !== 32'd55) $display("FAIL nob_after_edge got %h exp 55", b0_rs1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 5'd10, 32'hAAAA_0001, 5'd11, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 5'd10, 32'hBBBB_0002, 5'd11, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd11, 5'd10);
        n_checks++;
        if (b0_rs1 !== 32'hBBBB_0002 || b1_dbg !== 32'hBBBB_0002)
            $display("FAIL b2b_last_wins got %h/%h exp bbbb0002", b0_rs1, b1_dbg);
        else n_pass++;
        n_checks++;
        if (b0_rs2 !== 32'h0) $display("FAIL b2b_neighbour got %h exp 0", b0_rs2);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] e1, e2, e3, e4, e5;
            drive(($urandom_range(0, 29) != 0), 1'($urandom), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            e1 = exp_rd(rs1_addr, 1'b1);
            e2 = exp_rd(rs2_addr, 1'b1);
            e3 = exp_rd(dbg_addr, 1'b0);
            e4 = exp_rd(rs1_addr, 1'b0);
            e5 = exp_rd(rs2_addr, 1'b0);
            n_checks++;
            if (b1_rs1 !== e1 || b1_rs2 !== e2 || b1_dbg !== e3 ||
                b0_rs1 !== e4 || b0_rs2 !== e5 || b0_dbg !== e3)
                $display("FAIL random n=%0d got %h %h %h %h %h %h exp %h %h %h %h %h %h",
                         n, b1_rs1, b1_rs2, b1_dbg, b0_rs1, b0_rs2, b0_dbg,
                         e1, e2, e3, e4, e5, e3);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_x0();
        test_bypass();
        test_dual_bypass();
        test_reset_during_write();
        test_no_bypass_build();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_file
